// File: rtl/call_stack_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | call_stack_ctrl_if                                                         |
// | Call/return request, PC redirect and register-file stack signal bundle.     |
// | max_depth is present only when CALL_STACK_WATERMARK_EN is defined.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface call_stack_ctrl_if #(
  parameter int PC_WIDTH = 5
);
  logic                call_req;
  logic                ret_req;
  logic [PC_WIDTH-1:0] call_target;
  logic [PC_WIDTH-1:0] pc_return;
  logic                call_ack;
  logic                ret_ack;
  logic                pc_load;
  logic [PC_WIDTH-1:0] pc_load_value;
  logic                rf_stack_push;
  logic                rf_stack_pop;
  logic [PC_WIDTH-1:0] rf_stack_pointer;
  logic                busy;
  logic                overflow;
  logic                underflow;
`ifdef CALL_STACK_WATERMARK_EN
  logic [PC_WIDTH-1:0] max_depth;
`endif

  // master: the call-stack controller itself
  modport master (
    input  call_req, ret_req, call_target, pc_return,
    output call_ack, ret_ack, pc_load, pc_load_value,
    output rf_stack_push, rf_stack_pop, rf_stack_pointer,
`ifdef CALL_STACK_WATERMARK_EN
    output max_depth,
`endif
    output busy, overflow, underflow
  );

  // slave: decoder / PC logic / register file side
  modport slave (
    output call_req, ret_req, call_target, pc_return,
    input  call_ack, ret_ack, pc_load, pc_load_value,
    input  rf_stack_push, rf_stack_pop, rf_stack_pointer,
`ifdef CALL_STACK_WATERMARK_EN
    input  max_depth,
`endif
    input  busy, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/call_stack_ctrl.sv
// +----------------------------------------------------------------------------+
// | call_stack_ctrl                                                            |
// | CALL/RET controller: return-address LIFO, frame counter, PC redirect and    |
// | register-file context push/pop strobes. Optional CALL_STACK_WATERMARK_EN   |
// | adds a max_depth high-water mark.                                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module call_stack_ctrl #(
  parameter int PC_WIDTH = 5,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  call_stack_ctrl_if.master   bus
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LIFO_N = 1 << IDX_W;

  localparam logic [PC_WIDTH-1:0] c_depth = PC_WIDTH'(DEPTH);
  localparam logic [PC_WIDTH-1:0] c_one   = PC_WIDTH'(1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_push  = 2'd1;
  localparam logic [1:0] c_st_pop   = 2'd2;
  localparam logic [1:0] c_st_fault = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] sp_q, sp_d;
  logic [PC_WIDTH-1:0] pc_load_value_q, pc_load_value_d;
  logic [PC_WIDTH-1:0] ret_addr_q, ret_addr_d;
  logic                fault_call_q, fault_call_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
`ifdef CALL_STACK_WATERMARK_EN
  logic [PC_WIDTH-1:0] max_depth_q, max_depth_d;
`endif

  logic [PC_WIDTH-1:0] lifo_q [LIFO_N];

  logic [PC_WIDTH-1:0] w_sp_inc;
  logic [PC_WIDTH-1:0] w_sp_dec;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [IDX_W-1:0]    w_rd_idx;
  logic                w_lifo_we;

  assign w_sp_inc = sp_q + c_one;
  assign w_sp_dec = sp_q - c_one;
  assign w_wr_idx = sp_q[IDX_W-1:0];
  assign w_rd_idx = w_sp_dec[IDX_W-1:0];

  always_comb begin
    state_d         = state_q;
    sp_d            = sp_q;
    pc_load_value_d = pc_load_value_q;
    ret_addr_d      = ret_addr_q;
    fault_call_d    = fault_call_q;
    overflow_d      = overflow_q;
    underflow_d     = underflow_q;
    w_lifo_we       = 1'b0;
`ifdef CALL_STACK_WATERMARK_EN
    max_depth_d     = max_depth_q;
`endif
    case (state_q)
      c_st_idle: begin
        if (bus.call_req) begin
          ret_addr_d = bus.pc_return;
          if (sp_q < c_depth) begin
            // Redirect target is latched here so it holds after the PUSH cycle.
            pc_load_value_d = bus.call_target;
            state_d         = c_st_push;
          end else begin
            overflow_d   = 1'b1;
            fault_call_d = 1'b1;
            state_d      = c_st_fault;
          end
        end else if (bus.ret_req) begin
          if (sp_q != '0) begin
            pc_load_value_d = lifo_q[w_rd_idx];
            state_d         = c_st_pop;
          end else begin
            underflow_d  = 1'b1;
            fault_call_d = 1'b0;
            state_d      = c_st_fault;
          end
        end
      end
      c_st_push: begin
        w_lifo_we = 1'b1;
        sp_d      = w_sp_inc;
        state_d   = c_st_idle;
`ifdef CALL_STACK_WATERMARK_EN
        if (w_sp_inc > max_depth_q) begin
          max_depth_d = w_sp_inc;
        end
`endif
      end
      c_st_pop: begin
        sp_d    = w_sp_dec;
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= c_st_idle;
      sp_q            <= '0;
      pc_load_value_q <= '0;
      ret_addr_q      <= '0;
      fault_call_q    <= 1'b0;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
`ifdef CALL_STACK_WATERMARK_EN
      max_depth_q     <= '0;
`endif
    end else begin
      state_q         <= state_d;
      sp_q            <= sp_d;
      pc_load_value_q <= pc_load_value_d;
      ret_addr_q      <= ret_addr_d;
      fault_call_q    <= fault_call_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
`ifdef CALL_STACK_WATERMARK_EN
      max_depth_q     <= max_depth_d;
`endif
    end
  end

  // LIFO storage carries no reset; contents are only read below sp.
  always_ff @(posedge clk) begin
    if (rst_n && w_lifo_we) begin
      lifo_q[w_wr_idx] <= ret_addr_q;
    end
  end

  assign bus.rf_stack_push    = (state_q == c_st_push);
  assign bus.rf_stack_pop     = (state_q == c_st_pop);
  assign bus.pc_load          = (state_q == c_st_push) || (state_q == c_st_pop);
  assign bus.pc_load_value    = pc_load_value_q;
  assign bus.call_ack         = (state_q == c_st_push) ||
                                ((state_q == c_st_fault) && fault_call_q);
  assign bus.ret_ack          = (state_q == c_st_pop) ||
                                ((state_q == c_st_fault) && !fault_call_q);
  assign bus.rf_stack_pointer = sp_q;
  assign bus.busy             = (state_q != c_st_idle);
  assign bus.overflow         = overflow_q;
  assign bus.underflow        = underflow_q;
`ifdef CALL_STACK_WATERMARK_EN
  assign bus.max_depth        = max_depth_q;
`endif

endmodule

`default_nettype wire

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
Call/return controller that drives the register-file context-stack interface (rf_stack_push, rf_stack_pop, rf_stack_pointer) on subroutine CALL and RET.
Holds the return-address LIFO, owns the frame counter, and issues the PC redirect.
Sits between the instruction decoder/PC logic and the register file; it is the initiator for the register file's stack interface.

Parameters:
PC_WIDTH, 5, width of PC, call target, return address and rf_stack_pointer
DEPTH, 8, maximum nested frames; legal range 1 .. 2**PC_WIDTH-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
call_req  input  1  decoder requests CALL; held high until call_ack
ret_req  input  1  decoder requests RET; held high until ret_ack
call_target  input  PC_WIDTH  CALL destination; sampled in the accept cycle
pc_return  input  PC_WIDTH  address to return to (PC+1); sampled in the accept cycle
call_ack  output  1  one-cycle pulse: CALL finished (executed or faulted)
ret_ack  output  1  one-cycle pulse: RET finished (executed or faulted)
pc_load  output  1  one-cycle pulse: load pc_load_value into PC
pc_load_value  output  PC_WIDTH  redirect address
rf_stack_push  output  1  to register file: save context and clear working registers
rf_stack_pop  output  1  to register file: restore context
rf_stack_pointer  output  PC_WIDTH  current frame count (sp)
busy  output  1  high while not in IDLE
overflow  output  1  sticky: CALL attempted with sp==DEPTH
underflow  output  1  sticky: RET attempted with sp==0

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low.
- Reset (rst_n==0 at a rising edge):
  - state=IDLE, sp=0.
  - All outputs 0, including pc_load_value and the overflow/underflow flags.
  - LIFO contents are don't-care.
  - Reset has priority over everything. Reset during PUSH or POP aborts the operation: no ack, sp=0.
- rf_stack_pointer always equals registered sp. It changes only on the edge that ends a PUSH or POP cycle.
- FSM states: IDLE, PUSH, POP, FAULT.
- IDLE:
  - call_req=1 → capture call_target and pc_return.
    - sp<DEPTH → PUSH.
    - else → FAULT, and set overflow.
  - else ret_req=1:
    - sp>0 → POP.
    - else → FAULT, and set underflow.
  - call_req and ret_req both high: CALL wins; RET stays pending and is accepted in a later IDLE cycle.
- PUSH (exactly 1 cycle):
  - rf_stack_push=1, pc_load=1, pc_load_value=captured call_target, call_ack=1.
  - rf_stack_pointer=old sp; the register file saves the context into slot sp.
  - At the edge: lifo[sp]<=captured pc_return, sp<=sp+1, state → IDLE.
- POP (exactly 1 cycle):
  - rf_stack_pop=1, pc_load=1, pc_load_value=lifo[sp-1], ret_ack=1.
  - rf_stack_pointer=old sp (>0, so the register file's sp>0 gate passes); the context restores from slot sp-1.
  - At the edge: sp<=sp-1, state → IDLE.
- FAULT (exactly 1 cycle):
  - Acks the offending request: call_ack or ret_ack=1.
  - No push, no pop, no pc_load; sp unchanged.
  - → IDLE.
- Latency: a request seen in IDLE at edge N produces its outputs and ack during cycle N+1. Back-to-back operations run one every 2 cycles.
- The requester must drop its req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Strobes:
  - rf_stack_push and rf_stack_pop are never high together.
  - Each is high for exactly one cycle per operation.
  - pc_load_value holds its last value when pc_load=0.
- Flags: overflow and underflow are cleared only by reset.
- Arithmetic: sp is PC_WIDTH bits and never wraps. The bounds checks above guarantee 0 ≤ sp ≤ DEPTH.

Optional Feature:
Macro CALL_STACK_WATERMARK_EN.
- Defined:
  - Adds output max_depth [PC_WIDTH-1:0], reset to 0.
  - max_depth updates to sp+1 on a PUSH edge whenever sp+1 > max_depth.
  - It is never decreased except by reset.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
1. Reset, then one CALL (call_target=5'h12, pc_return=5'h04) → one cycle later rf_stack_push=1, rf_stack_pointer=0, pc_load=1, pc_load_value=5'h12, call_ack=1; next cycle rf_stack_pointer=1.
2. Follow-up RET → rf_stack_pop=1 with rf_stack_pointer=1, pc_load_value=5'h04, ret_ack=1; then rf_stack_pointer=0.
3. 8 CALLs with pc_return=1..8 → sp=8; 9th CALL → call_ack=1, no push, overflow=1, sp=8. Then 8 RETs → pc_load_value 8,7,...,1; sp=0.
4. RET at sp=0 → ret_ack=1, rf_stack_pop=0, pc_load=0, underflow=1; a later valid CALL still works and underflow stays 1.
5. call_req and ret_req asserted together at sp=1 → CALL first (sp=2, push), then RET (pop, sp=1); never both strobes in one cycle.
6. rst_n=0 during the PUSH cycle at sp=3 → next cycle all outputs 0, sp=0, flags 0. With CALL_STACK_WATERMARK_EN, max_depth=0 after reset and 8 after test 3.
